// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetch queue with in-order ibus request/response tracking and flush handling
//   clk, rst_n (async, active-low)
//   flush_i/flush_addr_i : redirect, stale in-flight responses are dropped
//   stall_i              : decode not accepting the head instruction
//   jtag_halt_i          : blocks new ibus requests only
//   ibus_*               : valid/ready request and response channels, responses in request order
//   inst_o/pc_o/inst_valid_o : registered queue head to decode
module ifu_prefetch #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OS   = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        stall_i,
    input  logic        jtag_halt_i,
    output logic [31:0] ibus_addr_o,
    output logic        ibus_req_valid_o,
    input  logic        ibus_req_ready_i,
    input  logic [31:0] ibus_data_i,
    input  logic        ibus_rsp_valid_i,
    output logic        ibus_rsp_ready_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o
);
    localparam int QW = $clog2(DEPTH);
    localparam int AW = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc, last_pc;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc [DEPTH];
    logic [QW-1:0] q_rd, q_wr;
    logic [CW-1:0] q_cnt, os_cnt, drop_cnt;
    logic [31:0]   af_addr [MAX_OS];
    logic [AW-1:0] af_rd, af_wr;
    logic [CW:0]   committed;
    logic          req_fire, rsp_fire, push, pop;

    function automatic logic [AW-1:0] af_next(input logic [AW-1:0] p);
        return (p == AW'(MAX_OS - 1)) ? '0 : p + 1'b1;
    endfunction

    // queue slots already taken plus slots promised to live (non-dropped) requests
    assign committed        = {1'b0, q_cnt} + {1'b0, os_cnt} - {1'b0, drop_cnt};
    assign ibus_rsp_ready_o = 1'b1;
    assign ibus_addr_o      = fetch_pc;
    assign ibus_req_valid_o = rst_n && !flush_i && !jtag_halt_i &&
                              os_cnt < CW'(MAX_OS) && committed < (CW + 1)'(DEPTH);
    assign req_fire         = ibus_req_valid_o && ibus_req_ready_i;
    assign rsp_fire         = ibus_rsp_valid_i && ibus_rsp_ready_o;
    assign inst_valid_o     = q_cnt != '0 && !flush_i;
    assign pop              = inst_valid_o && !stall_i;
    assign push             = rsp_fire && drop_cnt == '0 && !flush_i;
    assign inst_o           = inst_valid_o ? q_inst[q_rd] : NOP;
    assign pc_o             = inst_valid_o ? q_pc[q_rd] : last_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            last_pc  <= RESET_PC;
            q_rd     <= '0;
            q_wr     <= '0;
            q_cnt    <= '0;
            os_cnt   <= '0;
            drop_cnt <= '0;
            af_rd    <= '0;
            af_wr    <= '0;
        end else begin
            os_cnt <= os_cnt + CW'(req_fire) - CW'(rsp_fire);
            if (flush_i) begin
                fetch_pc <= flush_addr_i;
                q_rd     <= '0;
                q_wr     <= '0;
                q_cnt    <= '0;
                af_rd    <= '0;
                af_wr    <= '0;
                // every request still in flight after this edge becomes stale
                drop_cnt <= os_cnt - CW'(rsp_fire);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (req_fire) af_wr <= af_next(af_wr);
                if (push) af_rd <= af_next(af_rd);
                if (push) q_wr <= q_wr + 1'b1;
                if (pop) begin
                    last_pc <= q_pc[q_rd];
                    q_rd    <= q_rd + 1'b1;
                end
                q_cnt <= q_cnt + CW'(push) - CW'(pop);
                if (rsp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[q_wr] <= ibus_data_i;
            q_pc[q_wr]   <= af_addr[af_rd];
        end
        if (req_fire) af_addr[af_wr] <= fetch_pc;
    end

    assert property (@(posedge clk) disable iff (!rst_n) drop_cnt <= os_cnt);
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed tests of ifu_prefetch against a transaction-level queue model
module tb_ifu_prefetch;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OS   = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        flush_i = 1'b0, stall_i = 1'b0, jtag_halt_i = 1'b0;
    logic        ibus_req_ready_i = 1'b1, ibus_rsp_valid_i = 1'b0;
    logic [31:0] flush_addr_i = '0, ibus_data_i = '0;
    logic [31:0] ibus_addr_o, inst_o, pc_o;
    logic        ibus_req_valid_o, ibus_rsp_ready_o, inst_valid_o;

    ifu_prefetch #(.DEPTH(DEPTH), .MAX_OS(MAX_OS), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
        .stall_i(stall_i), .jtag_halt_i(jtag_halt_i), .ibus_addr_o(ibus_addr_o),
        .ibus_req_valid_o(ibus_req_valid_o), .ibus_req_ready_i(ibus_req_ready_i),
        .ibus_data_i(ibus_data_i), .ibus_rsp_valid_i(ibus_rsp_valid_i),
        .ibus_rsp_ready_o(ibus_rsp_ready_o), .inst_o(inst_o), .pc_o(pc_o),
        .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hAB00_0000 ^ a;
    endfunction

    typedef struct packed {logic [31:0] addr; logic stale;} req_t;
    typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;

    req_t        m_fl[$];
    ent_t        m_q[$];
    logic [31:0] m_fpc = RESET_PC, m_last = RESET_PC;

    logic        rsp_en = 1'b1;
    logic [31:0] pend[$];
    logic        bus_req = 1'b0, bus_rsp = 1'b0;
    logic [31:0] bus_addr = '0;

    always @(negedge clk) begin
        logic [31:0] e_inst, e_pc;
        logic        e_iv, e_rv;
        int          live;
        req_t        r;
        bus_req  = ibus_req_valid_o && ibus_req_ready_i;
        bus_addr = ibus_addr_o;
        bus_rsp  = ibus_rsp_valid_i && ibus_rsp_ready_o;
        if (!rst_n) begin
            m_fl.delete();
            m_q.delete();
            m_fpc  = RESET_PC;
            m_last = RESET_PC;
        end
        live = 0;
        foreach (m_fl[i]) if (!m_fl[i].stale) live++;
        e_iv   = rst_n && m_q.size() > 0 && !flush_i;
        e_inst = e_iv ? m_q[0].inst : NOP;
        e_pc   = e_iv ? m_q[0].pc : m_last;
        e_rv   = rst_n && !flush_i && !jtag_halt_i && m_fl.size() < MAX_OS && m_q.size() + live < DEPTH;
        chk("inst_valid", 32'(inst_valid_o), 32'(e_iv));
        chk("inst", inst_o, e_inst);
        chk("pc", pc_o, e_pc);
        chk("req_valid", 32'(ibus_req_valid_o), 32'(e_rv));
        chk("addr", ibus_addr_o, m_fpc);
        if (rst_n) begin
            if (flush_i) begin
                m_fpc = flush_addr_i;
                m_q.delete();
                if (ibus_rsp_valid_i && m_fl.size() > 0) r = m_fl.pop_front();
                foreach (m_fl[i]) m_fl[i].stale = 1'b1;
            end else begin
                if (e_iv && !stall_i) begin
                    m_last = m_q[0].pc;
                    void'(m_q.pop_front());
                end
                if (ibus_rsp_valid_i && m_fl.size() > 0) begin
                    r = m_fl.pop_front();
                    if (!r.stale) m_q.push_back('{pc: r.addr, inst: mem(r.addr)});
                end
                if (e_rv && ibus_req_ready_i) begin
                    m_fl.push_back('{addr: m_fpc, stale: 1'b0});
                    m_fpc += 32'd4;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n) pend.delete();
        else begin
            if (bus_rsp && pend.size() > 0) void'(pend.pop_front());
            if (bus_req) pend.push_back(bus_addr);
        end
        #2;
        ibus_rsp_valid_i = rst_n && rsp_en && pend.size() > 0;
        ibus_data_i      = pend.size() > 0 ? mem(pend[0]) : 32'h0;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!inst_valid_o && n < 10) begin
            tick();
            n++;
        end
        chk(name, 32'(inst_valid_o), 32'd1);
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(ibus_req_valid_o), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_pc", pc_o, RESET_PC);
        chk("rst_addr", ibus_addr_o, RESET_PC);
        tick(2);
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", 32'(ibus_req_valid_o), 32'd1);
        chk("first_req_addr", ibus_addr_o, RESET_PC);
        tick();
        chk("stream_not_yet", 32'(inst_valid_o), 32'd0);
        tick();
        chk("stream_first_valid", 32'(inst_valid_o), 32'd1);
        chk("stream_first_pc", pc_o, 32'h0);
        chk("stream_first_inst", inst_o, 32'hAB00_0000);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("stream_valid", 32'(inst_valid_o), 32'd1);
            chk("stream_pc", pc_o, 32'(4 * k));
        end

        stall_i = 1'b1;
        tick(10);
        chk("bp_req_stopped", 32'(ibus_req_valid_o), 32'd0);
        chk("bp_head_pc", pc_o, 32'd28);
        chk("bp_fetch_pc", ibus_addr_o, 32'd44);
        stall_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("bp_drain_valid", 32'(inst_valid_o), 32'd1);
            chk("bp_drain_pc", pc_o, 32'(32 + 4 * k));
        end

        rsp_en = 1'b0;
        tick(4);
        flush_i = 1'b1;
        flush_addr_i = 32'h100;
        #1;
        chk("flush_req_blocked", 32'(ibus_req_valid_o), 32'd0);
        tick();
        flush_i = 1'b0;
        rsp_en = 1'b1;
        wait_valid("flush_wait");
        chk("flush_pc", pc_o, 32'h100);
        chk("flush_inst", inst_o, 32'hAB00_0100);

        rsp_en = 1'b0;
        tick(4);
        flush_i = 1'b1;
        flush_addr_i = 32'h200;
        rsp_en = 1'b1;
        tick();
        flush_i = 1'b0;
        wait_valid("simul_wait");
        chk("simul_pc", pc_o, 32'h200);
        chk("simul_inst", inst_o, 32'hAB00_0200);

        rsp_en = 1'b0;
        tick(4);
        flush_i = 1'b1;
        flush_addr_i = 32'h280;
        tick();
        flush_addr_i = 32'h2C0;
        tick();
        flush_i = 1'b0;
        rsp_en = 1'b1;
        wait_valid("reflush_wait");
        chk("reflush_pc", pc_o, 32'h2C0);
        chk("reflush_inst", inst_o, 32'hAB00_02C0);

        tick(3);
        jtag_halt_i = 1'b1;
        flush_i = 1'b1;
        flush_addr_i = 32'h300;
        #1;
        chk("flush_hides_head", 32'(inst_valid_o), 32'd0);
        chk("flush_head_nop", inst_o, NOP);
        tick();
        flush_i = 1'b0;
        tick(10);
        jtag_halt_i = 1'b0;
        rsp_en = 1'b0;
        tick(2);
        jtag_halt_i = 1'b1;
        rsp_en = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("halt_no_req", 32'(ibus_req_valid_o), 32'd0);
            if (inst_valid_o) begin
                chk("halt_drain_pc", pc_o, 32'h300 + 32'(4 * n));
                n++;
            end
        end
        chk("halt_drain_count", 32'(n), 32'd2);
        chk("halt_idle_pc", pc_o, 32'h304);
        chk("halt_idle_inst", inst_o, NOP);
        jtag_halt_i = 1'b0;
        #1;
        chk("resume_req_valid", 32'(ibus_req_valid_o), 32'd1);
        chk("resume_addr", ibus_addr_o, 32'h308);

        tick(4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(ibus_req_valid_o), 32'd0);
        chk("mid_rst_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("mid_rst_inst", inst_o, NOP);
        chk("mid_rst_pc", pc_o, RESET_PC);
        chk("mid_rst_addr", ibus_addr_o, RESET_PC);
        tick(2);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_valid", 32'(ibus_req_valid_o), 32'd1);
        chk("post_rst_addr", ibus_addr_o, RESET_PC);
        tick();
        chk("post_rst_not_yet", 32'(inst_valid_o), 32'd0);
        tick();
        chk("post_rst_valid", 32'(inst_valid_o), 32'd1);
        chk("post_rst_pc", pc_o, RESET_PC);
        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
